// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit with HI/LO result registers.
//   Multiply uses radix-2 shift-add. Divide uses restoring shift-subtract.
//   Signed operations iterate on magnitudes, and the FIX state applies the signs.
//   Latency is fixed: WE rises WIDTH+2 edges after the accepting edge.
//
//   Optional feature: define MDU_CANCEL_EN to add the 'cancel' input.
//     With the feature, cancel in CALC/FIX aborts to IDLE with no WE.
//     Cancel together with start in IDLE/DONE suppresses the start.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active low
//   start   : request a new operation (sampled in IDLE/DONE only)
//   cancel  : abort request (only when MDU_CANCEL_EN is defined)
//   op      : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B    : multiplicand/multiplier or dividend/divisor
//   busy    : high in CALC and FIX
//   WE      : one-cycle result strobe (DONE)
//   HI_out  : product high half, or remainder (registered)
//   LO_out  : product low half, or quotient (registered)
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             WE,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] hi_r, lo_r, d_r;
  logic             neg_q, neg_r;

  logic abort;
`ifdef MDU_CANCEL_EN
  assign abort = cancel;
`else
  assign abort = 1'b0;
`endif

  logic accept, load, cnt_done;
  assign accept   = start && !abort;
  assign load     = ((state == IDLE) || (state == DONE)) && accept;
  // CALC spends one extra cycle at cnt==WIDTH. This cycle gives the fixed
  // WIDTH+2 edge latency.
  assign cnt_done = (cnt == CNT_W'(WIDTH));

  // Operand preparation: magnitudes for signed ops.
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg  = ~op[0] & A[WIDTH-1];
  assign b_neg  = ~op[0] & B[WIDTH-1];
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;
  assign b_zero = (B == '0);

  // One iteration step. Multiply: {hi,lo} holds {partial, multiplier}.
  // Divide: {hi,lo} holds {remainder, dividend/quotient}.
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff, hi_nxt, lo_nxt;
  logic             div_ge;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, d_r} : '0);
    div_shift = {hi_r, lo_r[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, d_r});
    div_diff  = div_shift[WIDTH-1:0] - d_r;
    hi_nxt    = mul_sum[WIDTH:1];
    lo_nxt    = {mul_sum[0], lo_r[WIDTH-1:1]};
    if (op_r[1]) begin
      hi_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_nxt = {lo_r[WIDTH-2:0], div_ge};
    end
  end

  // Sign correction applied in FIX. Unsigned ops have neg flags clear.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_res, lo_res;
  always_comb begin
    prod_fix = neg_q ? -{hi_r, lo_r} : {hi_r, lo_r};
    hi_res   = prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = prod_fix[WIDTH-1:0];
    if (op_r[1]) begin
      hi_res = neg_r ? -hi_r : hi_r;
      lo_res = neg_q ? -lo_r : lo_r;
    end
  end

  // FSM
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = CALC;
      CALC: begin
        if (abort)         next_state = IDLE;
        else if (cnt_done) next_state = FIX;
      end
      FIX:  next_state = abort ? IDLE : DONE;
      DONE: next_state = accept ? CALC : IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == CALC) || (state == FIX);
  assign WE   = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      op_r   <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      d_r    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      HI_out <= '0;
      LO_out <= '0;
    end else begin
      if (load) begin
        op_r <= op;
        hi_r <= '0;
        cnt  <= '0;
        if (op[1]) begin
          if (b_zero) begin
            // A zero divisor gives an all-ones quotient, and the raw dividend
            // passes through as the remainder. No signs are applied.
            lo_r  <= A;
            d_r   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
          end else begin
            lo_r  <= a_mag;
            d_r   <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
          end
        end else begin
          lo_r  <= b_mag;
          d_r   <= a_mag;
          neg_q <= a_neg ^ b_neg;
          neg_r <= 1'b0;
        end
      end else if ((state == CALC) && !cnt_done && !abort) begin
        hi_r <= hi_nxt;
        lo_r <= lo_nxt;
        cnt  <= cnt + 1'b1;
      end

      if ((state == FIX) && !abort) begin
        HI_out <= hi_res;
        LO_out <= lo_res;
      end
    end
  end

endmodule
